// File: rtl/pipelined_barrel_shifter.sv
// WIDTH-bit rotate/logical/arithmetic shifter, one register stage per amt bit.
// Optional sticky/zero flags port enabled by BARREL_SHIFTER_FLAGS_EN.
module pipelined_barrel_shifter #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   input  logic             lr,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef BARREL_SHIFTER_FLAGS_EN
   output logic [1:0]       flags,
`endif
   output logic [WIDTH-1:0] y
);

   function automatic logic [WIDTH-1:0] step(
      input logic [WIDTH-1:0] d,
      input int               n,
      input logic             en,
      input logic             rt,
      input logic [1:0]       md,
      input logic             sg
   );
      logic [2*WIDTH-1:0] t;
      logic [WIDTH-1:0]   r;
      logic               fill;
      t    = '0;
      r    = d;
      fill = (md == 2'b10) & rt & sg;
      if (en) begin
         if (md == 2'b00) begin
            t = {d, d};
            t = rt ? t >> n : t << n;
            r = rt ? t[WIDTH-1:0] : t[2*WIDTH-1:WIDTH];
         end else if (rt) begin
            t = {{WIDTH{fill}}, d} >> n;
            r = t[WIDTH-1:0];
         end else begin
            t = {{WIDTH{1'b0}}, d} << n;
            r = t[WIDTH-1:0];
         end
      end
      return r;
   endfunction

`ifdef BARREL_SHIFTER_FLAGS_EN
   function automatic logic lost(
      input logic [WIDTH-1:0] d,
      input int               n,
      input logic             en,
      input logic             rt,
      input logic [1:0]       md
   );
      logic [2*WIDTH-1:0] t;
      t = '0;
      if (en && md != 2'b00) begin
         if (rt)
            t = {d, {WIDTH{1'b0}}} >> n;
         else
            t = {{WIDTH{1'b0}}, d} << n;
      end
      return rt ? |t[WIDTH-1:0] : |t[2*WIDTH-1:WIDTH];
   endfunction
`endif

   logic [WIDTH-1:0] s_dat [AMT_W];
   logic [WIDTH-1:0] s_nxt [AMT_W];
   logic [AMT_W-1:0] s_amt [AMT_W];
   logic [1:0]       s_mode [AMT_W];
   logic             s_lr [AMT_W];
   logic             s_sgn [AMT_W];
   logic             s_vld [AMT_W];
   logic [AMT_W:0]   ld;
   logic             unused_tail;

   // A stage may take new data if empty or if its occupant moves on.
   always_comb begin
      ld        = '0;
      ld[AMT_W] = out_ready;
      for (int k = AMT_W - 1; k >= 0; k--)
         ld[k] = !s_vld[k] | ld[k+1];
   end

   assign in_ready = ld[0] & !reset;

`ifdef BARREL_SHIFTER_FLAGS_EN
   logic s_stk [AMT_W];
`endif

   for (genvar k = 0; k < AMT_W; k++) begin : g_stage
      logic [WIDTH-1:0] d_i;
      logic [AMT_W-1:0] amt_i;
      logic [1:0]       mode_i;
      logic             lr_i;
      logic             sgn_i;
      logic             v_i;
      logic [WIDTH-1:0] dat_q;
      logic [AMT_W-1:0] amt_q;
      logic [1:0]       mode_q;
      logic             lr_q;
      logic             sgn_q;
      logic             vld_q;

      if (k == 0) begin : g_head
         assign d_i    = a;
         assign amt_i  = amt;
         assign mode_i = mode;
         assign lr_i   = lr;
         assign sgn_i  = a[WIDTH-1];
         assign v_i    = in_valid;
      end else begin : g_body
         assign d_i    = s_dat[k-1];
         assign amt_i  = s_amt[k-1];
         assign mode_i = s_mode[k-1];
         assign lr_i   = s_lr[k-1];
         assign sgn_i  = s_sgn[k-1];
         assign v_i    = s_vld[k-1];
      end

      assign s_nxt[k] = step(d_i, 1 << k, amt_i[k],
                             lr_i, mode_i, sgn_i);

      always_ff @(posedge clk) begin
         if (reset) begin
            dat_q  <= '0;
            amt_q  <= '0;
            mode_q <= '0;
            lr_q   <= 1'b0;
            sgn_q  <= 1'b0;
            vld_q  <= 1'b0;
         end else if (ld[k]) begin
            dat_q  <= s_nxt[k];
            amt_q  <= amt_i;
            mode_q <= mode_i;
            lr_q   <= lr_i;
            sgn_q  <= sgn_i;
            vld_q  <= v_i;
         end
      end

      assign s_dat[k]  = dat_q;
      assign s_amt[k]  = amt_q;
      assign s_mode[k] = mode_q;
      assign s_lr[k]   = lr_q;
      assign s_sgn[k]  = sgn_q;
      assign s_vld[k]  = vld_q;

`ifdef BARREL_SHIFTER_FLAGS_EN
      logic stk_i;
      logic stk_q;
      if (k == 0) begin : g_stk_head
         assign stk_i = 1'b0;
      end else begin : g_stk_body
         assign stk_i = s_stk[k-1];
      end
      always_ff @(posedge clk) begin
         if (reset)
            stk_q <= 1'b0;
         else if (ld[k])
            stk_q <= stk_i | lost(d_i, 1 << k, amt_i[k],
                                  lr_i, mode_i);
      end
      assign s_stk[k] = stk_q;
`endif
   end

   // Final stage has no consumer for its control fields.
   always_comb begin
      unused_tail = s_lr[AMT_W-1] ^ s_sgn[AMT_W-1]
                  ^ (^s_mode[AMT_W-1]);
      for (int k = 0; k < AMT_W; k++)
         unused_tail = unused_tail ^ (^s_amt[k]);
   end

   assign y         = s_dat[AMT_W-1];
   assign out_valid = s_vld[AMT_W-1];

`ifdef BARREL_SHIFTER_FLAGS_EN
   logic z_q;
   always_ff @(posedge clk) begin
      if (reset)
         z_q <= 1'b0;
      else if (ld[AMT_W-1])
         z_q <= (s_nxt[AMT_W-1] == '0);
   end
   assign flags = {s_stk[AMT_W-1], z_q};
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised scoreboard bench for pipelined_barrel_shifter (WIDTH=8).
// Flags checks are compiled in with BARREL_SHIFTER_FLAGS_EN.
module tb_pipelined_barrel_shifter;
   localparam int W  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [AW-1:0] amt;
   logic          lr;
   logic [1:0]    mode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  y;
`ifdef BARREL_SHIFTER_FLAGS_EN
   logic [1:0]    flags;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipelined_barrel_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .amt(amt),
      .lr(lr),
      .mode(mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
`ifdef BARREL_SHIFTER_FLAGS_EN
      .flags(flags),
`endif
      .y(y)
   );

   // Returns {sticky, result}, built bit by bit from source positions.
   function automatic logic [W:0] ref_model(input logic [W-1:0] av,
                                            input int sh,
                                            input logic rt,
                                            input logic [1:0] md);
      logic [W-1:0] r;
      logic         st;
      int           src;
      r  = '0;
      st = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (md == 2'b00) begin
            r[i] = rt ? av[(i + sh) % W] : av[(i - sh + W) % W];
         end else if (rt) begin
            src  = i + sh;
            r[i] = (src < W) ? av[src] : (md == 2'b10 && av[W-1]);
         end else begin
            src  = i - sh;
            r[i] = (src >= 0) ? av[src] : 1'b0;
         end
      end
      if (md != 2'b00)
         for (int j = 0; j < sh; j++)
            st = st | (rt ? av[j] : av[W-1-j]);
      return {st, r};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beat();
      a    = W'($urandom);
      amt  = AW'($urandom);
      lr   = 1'($urandom);
      mode = 2'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; amt = '0; lr = 1'b0; mode = 2'b00;
      repeat (2) cyc();
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL reset_in_ready got %b want 0", in_ready);
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      tests++;
      if (y !== 8'h00) begin
         fails++; $display("FAIL reset_y got %h want 00", y);
      end
`ifdef BARREL_SHIFTER_FLAGS_EN
      tests++;
      if (flags !== 2'b00) begin
         fails++; $display("FAIL reset_flags got %b want 00", flags);
      end
`endif
      reset = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_latency();
      out_ready = 1'b1; in_valid = 1'b1;
      a = 8'b10010011; mode = 2'b00; lr = 1'b0; amt = 3'd1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL lat_in_ready got %b want 1", in_ready);
      end
      cyc();
      in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         tests++;
         if (out_valid !== (c == 3)) begin
            fails++;
            $display("FAIL lat_valid edge %0d got %b want %b", c, out_valid, c == 3);
         end
         if (c == 3) begin
            tests++;
            if (y !== 8'b00100111) begin
               fails++; $display("FAIL lat_y got %b want 00100111", y);
            end
         end
         cyc();
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] md_t [4] = '{2'b01, 2'b10, 2'b00, 2'b10};
      logic       lr_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0] am_t [4] = '{3'd3, 3'd3, 3'd2, 3'd3};
      logic [7:0] ex_t [4] = '{8'b00010010, 8'b11110010,
                               8'b11100100, 8'b10011000};
      logic [7:0] got [4];
      int         at [4];
      int         n = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            in_valid = 1'b1; a = 8'b10010011;
            mode = md_t[i]; lr = lr_t[i]; amt = am_t[i];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (i < 4) begin
            tests++;
            if (in_ready !== 1'b1) begin
               fails++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", i, in_ready);
            end
         end
         if (out_valid === 1'b1) begin
            if (n < 4) begin got[n] = y; at[n] = i; end
            n++;
         end
         cyc();
      end
      tests++;
      if (n != 4) begin
         fails++; $display("FAIL b2b_count got %0d want 4", n);
      end
      for (int j = 0; j < 4 && j < n; j++) begin
         tests++;
         if (got[j] !== ex_t[j]) begin
            fails++; $display("FAIL b2b_y[%0d] got %b want %b", j, got[j], ex_t[j]);
         end
         tests++;
         if (at[j] != j + 3) begin
            fails++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", j, at[j], j + 3);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0]  ba [5];
      logic [AW-1:0] bm [5];
      logic          bl [5];
      logic [1:0]    bd [5];
      logic [W-1:0]  q [$];
      logic [W-1:0]  held = '0;
      logic [W:0]    m;
      logic          have = 1'b0;
      int            idx = 0;
      int            nout = 0;
      int            c = 0;
      for (int i = 0; i < 5; i++) begin
         ba[i] = W'($urandom); bm[i] = AW'($urandom);
         bl[i] = 1'($urandom); bd[i] = 2'($urandom);
      end
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         in_valid = (idx < 5);
         if (idx < 5) begin
            a = ba[idx]; amt = bm[idx]; lr = bl[idx]; mode = bd[idx];
         end
         #1;
         if (in_valid && in_ready) begin
            m = ref_model(a, int'(amt), lr, mode);
            q.push_back(m[W-1:0]);
            idx++;
         end
         if (out_valid === 1'b1) begin
            if (have) begin
               tests++;
               if (y !== held) begin
                  fails++; $display("FAIL bp_stable got %h want %h", y, held);
               end
            end
            held = y; have = 1'b1;
         end
         cyc();
      end
      #1;
      tests++;
      if (idx != 3) begin
         fails++; $display("FAIL bp_accepted got %0d want 3", idx);
      end
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL bp_in_ready got %b want 0", in_ready);
      end
      out_ready = 1'b1;
      while (c < 30 && (idx < 5 || nout < 5)) begin
         in_valid = (idx < 5);
         if (idx < 5) begin
            a = ba[idx]; amt = bm[idx]; lr = bl[idx]; mode = bd[idx];
         end
         #1;
         if (out_valid === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
               fails++; $display("FAIL bp_extra got %h want none", y);
            end else if (y !== q[0]) begin
               fails++; $display("FAIL bp_y[%0d] got %h want %h", nout, y, q[0]);
            end
            if (q.size() != 0) void'(q.pop_front());
            nout++;
         end
         if (in_valid && in_ready) begin
            m = ref_model(a, int'(amt), lr, mode);
            q.push_back(m[W-1:0]);
            idx++;
         end
         cyc();
         c++;
      end
      in_valid = 1'b0;
      tests++;
      if (nout != 5 || q.size() != 0) begin
         fails++; $display("FAIL bp_drain got %0d outputs want 5", nout);
      end
   endtask

   task automatic test_random();
      logic [2*W+1:0] q [$];
      logic [2*W+1:0] e;
      logic [W:0]     m;
      logic [W-1:0]   held = '0;
      logic           stalled = 1'b0;
      int             sent = 0;
      int             recv = 0;
      int             c = 0;
      while (c < 3000 && recv < 200) begin
         if (sent < 200 && $urandom_range(9) < 7) begin
            in_valid = 1'b1; rand_beat();
            if ($urandom_range(7) == 0) amt = '0;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(9) < 6);
         #1;
         if (stalled) begin
            tests++;
            if (out_valid !== 1'b1 || y !== held) begin
               fails++; $display("FAIL rnd_stable got %b/%h want 1/%h", out_valid, y, held);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            tests++;
            if (q.size() == 0) begin
               fails++; $display("FAIL rnd_extra got %h want none", y);
            end else begin
               e = q.pop_front();
               if (y !== e[W-1:0]) begin
                  fails++; $display("FAIL rnd_y[%0d] got %h want %h", recv, y, e[W-1:0]);
               end
               if (e[2*W+1]) begin
                  tests++;
                  if (y !== e[2*W:W+1]) begin
                     fails++; $display("FAIL rnd_amt0 got %h want %h", y, e[2*W:W+1]);
                  end
               end
`ifdef BARREL_SHIFTER_FLAGS_EN
               tests++;
               if (flags !== {e[W], e[W-1:0] == '0}) begin
                  fails++; $display("FAIL rnd_flags got %b want %b", flags, {e[W], e[W-1:0] == '0});
               end
`endif
            end
            recv++;
         end
         stalled = (out_valid === 1'b1) && !out_ready;
         held    = y;
         if (in_valid && in_ready) begin
            m = ref_model(a, int'(amt), lr, mode);
            q.push_back({amt == '0, a, m});
            sent++;
         end
         cyc();
         c++;
      end
      in_valid = 1'b0;
      tests++;
      if (recv != 200 || q.size() != 0) begin
         fails++; $display("FAIL rnd_count got %0d want 200 (timeout or loss)", recv);
      end
   endtask

   task automatic test_reset_midflight();
      logic [W:0] m;
      int         n = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; rand_beat();
         #1;
         cyc();
      end
      in_valid = 1'b0; reset = 1'b1;
      #1;
      cyc();
      #1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL mid_reset_valid got %b want 0", out_valid);
      end
      tests++;
      if (y !== 8'h00) begin
         fails++; $display("FAIL mid_reset_y got %h want 00", y);
      end
      reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      a = 8'hC5; mode = 2'b01; lr = 1'b0; amt = 3'd2;
      m = ref_model(a, 2, 1'b0, 2'b01);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL mid_in_ready got %b want 1", in_ready);
      end
      cyc();
      in_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         #1;
         if (out_valid === 1'b1) begin
            n++;
            tests++;
            if (c != 3 || y !== m[W-1:0]) begin
               fails++; $display("FAIL mid_post got %h at edge %0d want %h at 3", y, c, m[W-1:0]);
            end
         end
         cyc();
      end
      tests++;
      if (n != 1) begin
         fails++; $display("FAIL mid_count got %0d want 1", n);
      end
   endtask

`ifdef BARREL_SHIFTER_FLAGS_EN
   task automatic test_flags();
      logic [W-1:0] fa [2] = '{8'h01, 8'b10010011};
      logic [1:0]   fm [2] = '{2'b01, 2'b00};
      logic         fl [2] = '{1'b1, 1'b0};
      logic [2:0]   fs [2] = '{3'd7, 3'd5};
      logic [1:0]   ef [2] = '{2'b11, 2'b00};
      logic         seen;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; a = fa[i]; mode = fm[i]; lr = fl[i]; amt = fs[i];
         #1;
         cyc();
         in_valid = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (out_valid === 1'b1) begin
               seen = 1'b1;
               tests++;
               if (flags !== ef[i]) begin
                  fails++; $display("FAIL flags[%0d] got %b want %b", i, flags, ef[i]);
               end
               if (i == 0) begin
                  tests++;
                  if (y !== 8'h00) begin
                     fails++; $display("FAIL flags_y got %h want 00", y);
                  end
               end
            end
            cyc();
         end
         tests++;
         if (!seen) begin
            fails++; $display("FAIL flags_timeout[%0d] got none want result", i);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midflight();
`ifdef BARREL_SHIFTER_FLAGS_EN
      test_flags();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
